// File: rtl/rot16_pkg.sv
// Shared constants, state encoding and rotate helper for the 16-bit
// rotate/unrotate family.
package rot16_pkg;

  localparam int W     = 16;
  localparam int NSTEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } urot_state_t;

  // Rotate left by n with pure wrap-around: y[i] = x[(i - n) mod 16].
  function automatic logic [W-1:0] rotl16(input logic [W-1:0] x, input logic [3:0] n);
    logic [W-1:0] y;
    logic [3:0]   idx;
    y = '0;
    for (int i = 0; i < W; i++) begin
      idx  = 4'(i) - n;
      y[i] = x[idx];
    end
    return y;
  endfunction

endpackage

// File: rtl/rotl_step16.sv
// One conditional rotate-left stage of the log shifter. The stage amount
// is 8 >> k, so stepping k = 0..3 walks through 8, 4, 2, 1.
module rotl_step16
  import rot16_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [1:0]   k,
  input  logic         en,
  output logic [W-1:0] y
);

  logic [3:0] step_amt;

  // Select the stage amount and apply the rotate only when this bit of the amount is set.
  always_comb begin
    step_amt = 4'd8 >> k;
    y        = en ? rotl16(x, step_amt) : x;
  end

endmodule

// File: rtl/unrotate16b_seq.sv
// Sequential 16-bit rotate-left (inverse of the barrel rotate-right).
// One rotl_step16 stage is reused for four cycles, largest amount first.
//
// Handshake: a job is accepted on any rising edge where start=1 and the
// block is in IDLE or DONE (reset low blocks acceptance). a and s3..s0 are
// captured on that edge only. busy is high for the four RUN cycles; done
// is a one-cycle pulse and w is valid from that cycle until the next job
// completes. start during RUN is dropped, not queued.
module unrotate16b_seq
  import rot16_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic         s3,
  input  logic         s2,
  input  logic         s1,
  input  logic         s0,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] w,
  output urot_state_t  dbg_state
);

  urot_state_t  state_q, state_d;
  logic [W-1:0] r_q, r_d;
  logic [3:0]   amt_q, amt_d;
  logic [1:0]   k_q, k_d;
  logic [W-1:0] w_q, w_d;

  logic [W-1:0] step_y;
  logic [1:0]   bit_sel;
  logic         step_en;

  // Amount bit for this step: amt[3] pairs with rotate-by-8, amt[0] with rotate-by-1.
  always_comb begin
    bit_sel = 2'd3 - k_q;
    step_en = amt_q[bit_sel];
  end

  rotl_step16 u_step (
    .x  (r_q),
    .k  (k_q),
    .en (step_en),
    .y  (step_y)
  );

  // Next-state logic: accept in IDLE/DONE, step through RUN, publish w on the last step.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    amt_d   = amt_q;
    k_d     = k_q;
    w_d     = w_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          r_d     = a;
          amt_d   = {s3, s2, s1, s0};
          k_d     = 2'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d = step_y;
        k_d = k_q + 2'd1;
        if (k_q == 2'(NSTEP - 1)) begin
          w_d     = step_y;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      r_q     <= '0;
      amt_q   <= '0;
      k_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      amt_q   <= amt_d;
      k_q     <= k_d;
      w_q     <= w_d;
    end
  end

  // Outputs decode straight from registered state, so there is no input-to-output path.
  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    w         = w_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_unrotate16b_seq.sv
// Bench for unrotate16b_seq: directed cases from the test plan plus a
// randomized round-trip through a behavioural barrel-rotator model.
// Inputs change and outputs are sampled on the falling edge.
module tb_unrotate16b_seq;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [15:0] a;
  logic        s3, s2, s1, s0;
  logic        busy;
  logic        done;
  logic [15:0] w;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_pass;
  logic [15:0] last_w;

  unrotate16b_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .a         (a),
    .s3        (s3),
    .s2        (s2),
    .s1        (s1),
    .s0        (s0),
    .busy      (busy),
    .done      (done),
    .w         (w),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: rotate-left by s, written with plain integer arithmetic.
  function automatic logic [15:0] ref_unrot(input logic [15:0] x, input int s);
    int v;
    v = int'(x);
    return 16'(((v << s) | (v >> (16 - s))) & 32'hFFFF);
  endfunction

  // Reference barrel rotator: rotate-right by s.
  function automatic logic [15:0] ref_barrel(input logic [15:0] x, input int s);
    int v;
    v = int'(x);
    return 16'(((v >> s) | (v << (16 - s))) & 32'hFFFF);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns at the falling edge just after E0.
  task automatic drive_start(input logic [15:0] av, input logic [3:0] sv);
    a = av;
    {s3, s2, s1, s0} = sv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks the four RUN cycles and the done cycle; returns in the done cycle.
  task automatic expect_job(input string tag, input logic [15:0] exp);
    for (int c = 0; c < 4; c++) begin
      check({tag, "_busy"}, 16'(busy), 16'd1);
      check({tag, "_nodone"}, 16'(done), 16'd0);
      check({tag, "_whold"}, w, last_w);
      @(negedge clk);
    end
    check({tag, "_done"}, 16'(done), 16'd1);
    check({tag, "_busy_off"}, 16'(busy), 16'd0);
    check({tag, "_w"}, w, exp);
    last_w = exp;
  endtask

  task automatic full_job(input string tag, input logic [15:0] av, input logic [3:0] sv,
                          input logic [15:0] exp);
    drive_start(av, sv);
    expect_job(tag, exp);
    @(negedge clk);
    check({tag, "_pulse_end"}, 16'(done), 16'd0);
    check({tag, "_w_kept"}, w, exp);
  endtask

  initial begin
    logic [15:0] av, bv, rot;
    logic [3:0]  sv;
    int          dc;

    n_checks = 0;
    n_pass   = 0;
    last_w   = 16'h0000;
    rstn  = 1'b0;
    start = 1'b0;
    a     = 16'h0000;
    {s3, s2, s1, s0} = 4'd0;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_w", w, 16'h0000);
    check("rst_state", 16'(dbg_state), 16'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed cases
    full_job("single_bit", 16'h0001, 4'd1, 16'h0002);
    full_job("wrap_msb", 16'h8000, 4'd1, 16'h0001);
    full_job("nibble", 16'h1234, 4'd4, 16'h2341);
    full_job("zero_amt", 16'hABCD, 4'd0, 16'hABCD);
    full_job("amt15", 16'h0001, 4'd15, 16'h8000);

    // Round-trip over all amounts with random words
    for (int s = 0; s < 16; s++) begin
      av  = 16'($urandom_range(0, 65535));
      rot = ref_barrel(av, s);
      drive_start(rot, 4'(s));
      expect_job("rt", ref_unrot(rot, s));
      check("rt_roundtrip", w, av);
      @(negedge clk);
    end

    // Start while busy is ignored
    av = 16'($urandom_range(0, 65535));
    bv = ~av;
    sv = 4'($urandom_range(1, 15));
    drive_start(av, sv);
    dc = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) begin
        a = bv;
        {s3, s2, s1, s0} = ~sv;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) dc++;
      @(negedge clk);
    end
    check("busy_start_done_cnt", 16'(dc), 16'd1);
    check("busy_start_w", w, ref_unrot(av, int'(sv)));
    check("busy_start_idle", 16'(busy), 16'd0);
    last_w = ref_unrot(av, int'(sv));

    // Back-to-back jobs
    av = 16'($urandom_range(0, 65535));
    bv = 16'($urandom_range(0, 65535));
    drive_start(av, 4'd5);
    expect_job("b2b_a", ref_unrot(av, 5));
    drive_start(bv, 4'd11);
    expect_job("b2b_b", ref_unrot(bv, 11));
    @(negedge clk);
    check("b2b_pulse_end", 16'(done), 16'd0);

    // Reset during RUN cycle 3
    drive_start(16'hF00F, 4'd3);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_done", 16'(done), 16'd0);
    check("midrst_w", w, 16'h0000);
    dc = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) dc++;
      @(negedge clk);
    end
    check("midrst_no_done", 16'(dc), 16'd0);
    last_w = 16'h0000;
    full_job("after_rst", 16'h00F0, 4'd6, 16'h3C00);

    // Reset wins over start
    rstn  = 1'b0;
    a     = 16'h5555;
    {s3, s2, s1, s0} = 4'd2;
    start = 1'b1;
    @(negedge clk);
    rstn  = 1'b1;
    start = 1'b0;
    check("rst_wins_busy", 16'(busy), 16'd0);
    check("rst_wins_w", w, 16'h0000);
    @(negedge clk);
    check("rst_wins_still_idle", 16'(busy), 16'd0);
    check("rst_wins_no_done", 16'(done), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
